// File: rtl/turn_scheduler_if.sv
// Control/status bundle between the game controller and turn_scheduler.
// Latency: n/a (wires only); all scheduler-driven signals are registered in the scheduler.
// Backpressure: none; the scheduler samples inputs every clock.
interface turn_scheduler_if #(
  parameter int TURN_SECONDS = 15,
  parameter int MAX_STRIKES  = 3
);
  localparam int SW = $clog2(TURN_SECONDS + 1);
  localparam int KW = $clog2(MAX_STRIKES + 1);

  logic          start;
  logic          move_done;
  logic          game_over;
  logic          pause;
  logic          player;
  logic          turn_active;
  logic [SW-1:0] secs_left;
  logic          timeout_pulse;
  logic [KW-1:0] strikes0;
  logic [KW-1:0] strikes1;
  logic          done;
  logic          forfeit;
  logic          loser;

  // Controller side: drives the requests, observes the turn state.
  modport master (
    output start, move_done, game_over, pause,
    input  player, turn_active, secs_left, timeout_pulse,
           strikes0, strikes1, done, forfeit, loser
  );

  // Scheduler side.
  modport slave (
    input  start, move_done, game_over, pause,
    output player, turn_active, secs_left, timeout_pulse,
           strikes0, strikes1, done, forfeit, loser
  );
endinterface

// File: rtl/turn_scheduler.sv
// Two-player turn sequencer: per-turn timer, strike counting, forfeit on strike limit.
// Latency: outputs registered; move_done in cycle N -> SWITCH in N+1 -> next player's TURN in N+2.
// Backpressure: none; start/move_done/game_over/pause are sampled every cycle, no handshake.
module turn_scheduler #(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int TURN_SECONDS   = 15,
  parameter int MAX_STRIKES    = 3
) (
  input logic             clk,
  input logic             rst,
  turn_scheduler_if.slave bus
);
  localparam int SW = $clog2(TURN_SECONDS + 1);
  localparam int KW = $clog2(MAX_STRIKES + 1);
  localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;

  localparam logic [PW-1:0] PRES_LAST = PW'(CYCLES_PER_SEC - 1);
  localparam logic [SW-1:0] SECS_INIT = SW'(TURN_SECONDS);
  localparam logic [KW-1:0] STRIKE_LIM = KW'(MAX_STRIKES);

  typedef enum logic [1:0] {IDLE, TURN, SWITCH, DONE} state_t;

  state_t        state_q, state_n;
  logic          player_q, player_n;
  logic [SW-1:0] secs_q, secs_n;
  logic [PW-1:0] pres_q, pres_n;
  logic          tpulse_q, tpulse_n;
  logic [KW-1:0] s0_q, s0_n;
  logic [KW-1:0] s1_q, s1_n;
  logic          forfeit_q, forfeit_n;
  logic          loser_q, loser_n;
  logic          active_q, done_q;

  logic          sec_tick;
  logic [KW-1:0] strike_inc;

  // One-second tick from the prescaler, and the current player's incremented strike count.
  always_comb begin
    sec_tick   = !bus.pause && (pres_q == PRES_LAST);
    strike_inc = (player_q ? s1_q : s0_q) + KW'(1);
  end

  // Next-state and next-output logic; priority in TURN is game_over > move_done > expiry.
  always_comb begin
    state_n   = state_q;
    player_n  = player_q;
    secs_n    = secs_q;
    pres_n    = pres_q;
    tpulse_n  = 1'b0;
    s0_n      = s0_q;
    s1_n      = s1_q;
    forfeit_n = forfeit_q;
    loser_n   = loser_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n   = TURN;
          player_n  = 1'b0;
          secs_n    = SECS_INIT;
          pres_n    = '0;
          s0_n      = '0;
          s1_n      = '0;
          forfeit_n = 1'b0;
          loser_n   = 1'b0;
        end
      end

      TURN: begin
        if (bus.game_over) begin
          state_n   = DONE;
          forfeit_n = 1'b0;
        end else if (bus.move_done) begin
          // A move wins over a coincident expiry: timer frozen, no strike.
          state_n = SWITCH;
          if (player_q) s1_n = '0;
          else          s0_n = '0;
        end else if (!bus.pause) begin
          if (sec_tick) begin
            pres_n = '0;
            secs_n = secs_q - SW'(1);
            if (secs_q == SW'(1)) begin
              tpulse_n = 1'b1;
              if (player_q) s1_n = strike_inc;
              else          s0_n = strike_inc;
              if (strike_inc == STRIKE_LIM) begin
                state_n   = DONE;
                forfeit_n = 1'b1;
                loser_n   = player_q;
              end else begin
                state_n = SWITCH;
              end
            end
          end else begin
            pres_n = pres_q + PW'(1);
          end
        end
      end

      SWITCH: begin
        if (bus.game_over) begin
          state_n   = DONE;
          forfeit_n = 1'b0;
        end else begin
          state_n  = TURN;
          player_n = !player_q;
          pres_n   = '0;
          secs_n   = SECS_INIT;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and output registers; turn_active/done are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      player_q  <= 1'b0;
      secs_q    <= SECS_INIT;
      pres_q    <= '0;
      tpulse_q  <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      forfeit_q <= 1'b0;
      loser_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      player_q  <= player_n;
      secs_q    <= secs_n;
      pres_q    <= pres_n;
      tpulse_q  <= tpulse_n;
      s0_q      <= s0_n;
      s1_q      <= s1_n;
      forfeit_q <= forfeit_n;
      loser_q   <= loser_n;
      active_q  <= (state_n == TURN);
      done_q    <= (state_n == DONE);
    end
  end

  assign bus.player        = player_q;
  assign bus.turn_active   = active_q;
  assign bus.secs_left     = secs_q;
  assign bus.timeout_pulse = tpulse_q;
  assign bus.strikes0      = s0_q;
  assign bus.strikes1      = s1_q;
  assign bus.done          = done_q;
  assign bus.forfeit       = forfeit_q;
  assign bus.loser         = loser_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with CYCLES_PER_SEC=4, TURN_SECONDS=3, MAX_STRIKES=2.
// Inputs change and outputs are checked 1 time unit after each rising clock edge.
// Expected values are hand-derived: one second = 4 cycles, a full turn = 12 cycles.
module tb_turn_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  turn_scheduler_if #(.TURN_SECONDS(3), .MAX_STRIKES(2)) bus ();

  turn_scheduler #(
    .CYCLES_PER_SEC(4),
    .TURN_SECONDS  (3),
    .MAX_STRIKES   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = !clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_move();
    bus.move_done = 1'b1;
    tick();
    bus.move_done = 1'b0;
  endtask

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start     = 1'b0;
    bus.move_done = 1'b0;
    bus.game_over = 1'b0;
    bus.pause     = 1'b0;

    // Reset values.
    tick();
    tick();
    chk("rst_player", bus.player, 0);
    chk("rst_active", bus.turn_active, 0);
    chk("rst_secs", bus.secs_left, 3);
    chk("rst_tpulse", bus.timeout_pulse, 0);
    chk("rst_strikes0", bus.strikes0, 0);
    chk("rst_strikes1", bus.strikes1, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_forfeit", bus.forfeit, 0);
    chk("rst_loser", bus.loser, 0);
    rst = 1'b0;
    tick();
    chk("idle_stays", bus.turn_active, 0);

    // 1: start, no moves -> timeout 12 cycles after turn_active rises.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t1_active", bus.turn_active, 1);
    chk("t1_player", bus.player, 0);
    chk("t1_secs", bus.secs_left, 3);
    repeat (4) tick();
    chk("t1_secs_after_1s", bus.secs_left, 2);
    repeat (7) tick();
    chk("t1_no_pulse_early", bus.timeout_pulse, 0);
    chk("t1_secs_before_exp", bus.secs_left, 1);
    tick();
    chk("t1_tpulse", bus.timeout_pulse, 1);
    chk("t1_secs_zero", bus.secs_left, 0);
    chk("t1_switch_inactive", bus.turn_active, 0);
    chk("t1_strikes0", bus.strikes0, 1);
    chk("t1_player_still0", bus.player, 0);
    tick();
    chk("t1_tpulse_clears", bus.timeout_pulse, 0);
    chk("t1_player1", bus.player, 1);
    chk("t1_active1", bus.turn_active, 1);
    chk("t1_secs_reload", bus.secs_left, 3);

    // 2: player 1 moves early; then player 0 moves at cycle 5 of its turn.
    bus.start = 1'b1;           // ignored in TURN
    tick();
    bus.start = 1'b0;
    chk("t2_start_ignored", bus.player, 1);
    tick();
    pulse_move();
    chk("t2_switch_p1", bus.turn_active, 0);
    chk("t2_secs_frozen_p1", bus.secs_left, 3);
    tick();
    chk("t2_player0", bus.player, 0);
    chk("t2_strikes0_kept", bus.strikes0, 1);
    repeat (4) tick();
    chk("t2_secs_c4", bus.secs_left, 2);
    pulse_move();
    chk("t2_switch", bus.turn_active, 0);
    chk("t2_no_tpulse", bus.timeout_pulse, 0);
    chk("t2_strikes0_clr", bus.strikes0, 0);
    chk("t2_secs_frozen", bus.secs_left, 2);
    tick();
    chk("t2_player1", bus.player, 1);
    chk("t2_secs3", bus.secs_left, 3);
    chk("t2_active", bus.turn_active, 1);

    // 3: p1 moves, p0 times out, p1 moves, p0 times out again -> forfeit.
    pulse_move();
    tick();
    chk("t3_p0_turn", bus.player, 0);
    repeat (12) tick();
    chk("t3_tpulse1", bus.timeout_pulse, 1);
    chk("t3_strikes0_1", bus.strikes0, 1);
    chk("t3_not_done", bus.done, 0);
    tick();
    chk("t3_p1_turn", bus.player, 1);
    pulse_move();
    tick();
    chk("t3_p0_again", bus.player, 0);
    repeat (11) tick();
    chk("t3_no_pulse_yet", bus.timeout_pulse, 0);
    tick();
    chk("t3_tpulse2", bus.timeout_pulse, 1);
    chk("t3_done", bus.done, 1);
    chk("t3_forfeit", bus.forfeit, 1);
    chk("t3_loser", bus.loser, 0);
    chk("t3_strikes0_2", bus.strikes0, 2);
    chk("t3_inactive", bus.turn_active, 0);
    pulse_move();               // ignored in DONE
    tick();
    chk("t3_tpulse_once", bus.timeout_pulse, 0);
    chk("t3_done_holds", bus.done, 1);
    chk("t3_strikes_frozen", bus.strikes0, 2);
    chk("t3_secs_frozen", bus.secs_left, 0);
    chk("t3_player_frozen", bus.player, 0);

    // 4: restart from DONE, pause 10 cycles mid-turn -> expiry 10 cycles late.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t4_forfeit_clr", bus.forfeit, 0);
    chk("t4_done_clr", bus.done, 0);
    chk("t4_strikes0_clr", bus.strikes0, 0);
    chk("t4_player0", bus.player, 0);
    chk("t4_secs3", bus.secs_left, 3);
    repeat (5) tick();
    chk("t4_secs_pre_pause", bus.secs_left, 2);
    bus.pause = 1'b1;
    repeat (10) tick();
    bus.pause = 1'b0;
    chk("t4_secs_paused", bus.secs_left, 2);
    chk("t4_no_pulse_paused", bus.timeout_pulse, 0);
    repeat (6) tick();
    chk("t4_no_pulse_e21", bus.timeout_pulse, 0);
    chk("t4_secs1", bus.secs_left, 1);
    tick();
    chk("t4_tpulse_e22", bus.timeout_pulse, 1);
    chk("t4_strikes0", bus.strikes0, 1);
    tick();
    chk("t4_player1", bus.player, 1);

    // 5: move_done on the exact expiry cycle; then game_over with move_done.
    repeat (11) tick();
    pulse_move();
    chk("t5_no_tpulse", bus.timeout_pulse, 0);
    chk("t5_no_strike", bus.strikes1, 0);
    chk("t5_secs_frozen", bus.secs_left, 1);
    chk("t5_switch", bus.turn_active, 0);
    tick();
    chk("t5_player0", bus.player, 0);
    repeat (2) tick();
    bus.game_over = 1'b1;
    bus.move_done = 1'b1;
    tick();
    bus.game_over = 1'b0;
    bus.move_done = 1'b0;
    chk("t5_done", bus.done, 1);
    chk("t5_forfeit0", bus.forfeit, 0);
    chk("t5_inactive", bus.turn_active, 0);
    chk("t5_move_overridden", bus.strikes0, 1);

    // 6: reset mid-TURN with a live strike, then a fresh game.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulse_move();
    tick();
    chk("t6_p1", bus.player, 1);
    repeat (12) tick();
    chk("t6_strikes1", bus.strikes1, 1);
    repeat (3) tick();
    chk("t6_p0_active", bus.turn_active, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_active", bus.turn_active, 0);
    chk("t6_async_strikes1", bus.strikes1, 0);
    chk("t6_async_secs", bus.secs_left, 3);
    chk("t6_async_done", bus.done, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle", bus.turn_active, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t6_fresh_player", bus.player, 0);
    chk("t6_fresh_active", bus.turn_active, 1);
    repeat (4) tick();
    chk("t6_fresh_secs2", bus.secs_left, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Two-player turn sequencer for the game controller: owns the per-turn timeout counter, decides whose turn it is, and advances turns on a committed move or on turn expiry. It counts consecutive timeouts per player, ends the game by forfeit when a player reaches the strike limit, and publishes a seconds-remaining value for the display. It sits between the move-entry logic (move_done) and the win/draw detector (game_over) and the display/LED drivers.

## Interface
- CYCLES_PER_SEC, default 50_000_000: clk cycles per displayed second.
- TURN_SECONDS, default 15: turn length in seconds; must be ≥1.
- MAX_STRIKES, default 3: consecutive timeouts that forfeit a player; must be ≥1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level/pulse; starts a game from IDLE or DONE.
- move_done  in  1  one-cycle pulse: current player committed a move.
- game_over  in  1  win/draw detected externally; ends game.
- pause  in  1  freezes the turn timer while high.
- player  out  1  current player (0/1).
- turn_active  out  1  high while in TURN.
- secs_left  out  $clog2(TURN_SECONDS+1)  seconds remaining in turn.
- timeout_pulse  out  1  one-cycle pulse on turn expiry.
- strikes0, strikes1  out  $clog2(MAX_STRIKES+1)  consecutive-timeout counts.
- done  out  1  high in DONE.
- forfeit  out  1  game ended by strike limit (valid while done).
- loser  out  1  forfeiting player (valid while forfeit).

## Operation
- States: IDLE, TURN, SWITCH, DONE. All state and outputs registered.
- Reset values: state IDLE, player 0, turn_active 0, secs_left TURN_SECONDS, timeout_pulse 0, strikes 0, done 0, forfeit 0, loser 0, prescaler 0.
- IDLE: start → TURN; player 0, strikes cleared, prescaler 0, secs_left TURN_SECONDS.
- TURN, per cycle with pause low: prescaler increments; at prescaler == CYCLES_PER_SEC-1 it wraps to 0 and secs_left decrements. pause high holds prescaler and secs_left.
- Expiry: the wrap that takes secs_left 1→0. Then strikes[player]++ and timeout_pulse is asserted next cycle. If the new count == MAX_STRIKES → DONE with forfeit 1, loser = player; otherwise → SWITCH.
- move_done in TURN (paused or not): strikes[player] cleared → SWITCH. secs_left freezes at its current value.
- game_over in TURN or SWITCH → DONE with forfeit 0.
- Priority in one cycle: game_over > move_done > expiry. A move_done coincident with expiry counts as a move: no strike and no timeout_pulse.
- SWITCH: lasts one cycle, turn_active 0. On exit: player toggles, prescaler 0, secs_left TURN_SECONDS → TURN.
- DONE: outputs hold; secs_left, player and strikes are frozen. start → TURN with the same initialization as from IDLE, and forfeit/loser are cleared.
- move_done and pause are ignored outside TURN. start is ignored in TURN and SWITCH.
- strikes never exceed MAX_STRIKES. Counting saturates because DONE is entered at the limit.

## Timing
- Expiry falls on exactly TURN_SECONDS*CYCLES_PER_SEC unpaused TURN cycles after TURN entry.
- Cycle after expiry: timeout_pulse 1, secs_left 0, state SWITCH or DONE, turn_active 0.
- move_done sampled in cycle N: SWITCH in N+1, TURN with the toggled player and a reloaded secs_left in N+2.
- Turn-to-turn overhead is exactly one SWITCH cycle. The timer does not count in SWITCH.
- rst at any point returns to IDLE reset values asynchronously. A game in progress is discarded.

## Test plan
- CYCLES_PER_SEC=4, TURN_SECONDS=3, MAX_STRIKES=2. Pulse start, then no moves → timeout_pulse 12 cycles after turn_active rises, strikes0=1, player becomes 1 two cycles later.
- Same parameters. Move at cycle 5 of player 0's turn → no timeout_pulse, SWITCH for 1 cycle, player 1 with secs_left=3, strikes0=0.
- Player 0 times out, player 1 moves, player 0 times out again → done=1, forfeit=1, loser=0, strikes0=2.
- Hold pause for 10 cycles mid-turn → secs_left and prescaler frozen; expiry occurs 10 cycles later than without pause.
- move_done on the exact expiry cycle → no strike, no timeout_pulse. game_over together with move_done → DONE, forfeit=0.
- Assert rst mid-TURN → all outputs at reset values immediately. start after rst release → fresh game with player 0.
